// File: rtl/nios2_fp_mult_pkg.sv
// Shared definitions for the Nios II M-stage pipelined multiplier:
// op encodings, default widths and the signed high-half correction term.
package nios2_fp_mult_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_PART_W = 16;
  localparam int unsigned MAX_W      = 128;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULXUU = 2'b01,
    MULXSU = 2'b10,
    MULXSS = 2'b11
  } mul_op_e;

  // Turns the unsigned high half into the signed one: subtract B when A is
  // negative and A when B is negative (mod 2^w). Operands are zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] hi_correction(input logic [MAX_W-1:0] a,
                                                     input logic [MAX_W-1:0] b,
                                                     input mul_op_e          op,
                                                     input int unsigned      w);
    logic [MAX_W-1:0] a_top;
    logic [MAX_W-1:0] b_top;
    logic             sign_a;
    logic             sign_b;
    a_top  = a >> (w - 1);
    b_top  = b >> (w - 1);
    sign_a = a_top[0] & op[1];
    sign_b = b_top[0] & (op == MULXSS);
    return (sign_a ? b : '0) + (sign_b ? a : '0);
  endfunction

endpackage

// File: rtl/nios2_fp_mult_slice.sv
// Registered PART_W x PART_W unsigned multiplier with enable and async clear;
// one instance per slice-pair so each maps onto a DSP block.
module nios2_fp_mult_slice
  import nios2_fp_mult_pkg::*;
#(
  parameter int unsigned PART_W = DEF_PART_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PART_W-1:0]     a,
  input  logic [PART_W-1:0]     b,
  output logic [2*PART_W-1:0]   p
);

  logic [2*PART_W-1:0] a_ext;
  logic [2*PART_W-1:0] b_ext;

  assign a_ext = {{PART_W{1'b0}}, a};
  assign b_ext = {{PART_W{1'b0}}, b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/nios2_fp_cpu_mult_pipe.sv
// Three-stage pipelined integer multiplier (MUL / MULXUU / MULXSU / MULXSS)
// with global stall enable and synchronous flush of in-flight operations.
module nios2_fp_cpu_mult_pipe
  import nios2_fp_mult_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PART_W = DEF_PART_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mul_en,
  input  logic              mul_flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] mul_src1,
  input  logic [DATA_W-1:0] mul_src2,
  input  logic [1:0]        mul_op,
  output logic              out_valid,
  output logic [DATA_W-1:0] mul_result,
  output logic              busy
);

  localparam int unsigned N      = DATA_W / PART_W;
  localparam int unsigned PP_W   = 2 * PART_W;
  localparam int unsigned PROD_W = 2 * DATA_W;

  if (((DATA_W % PART_W) != 0) || (DATA_W > MAX_W)) begin : g_bad_width
    $error("nios2_fp_cpu_mult_pipe: DATA_W must be a multiple of PART_W and at most MAX_W");
  end

  logic              s1_valid;
  logic              s2_valid;
  logic              s3_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  mul_op_e           s1_op;
  mul_op_e           s2_op;
  logic [DATA_W-1:0] s2_c;
  logic [PP_W-1:0]   pp [N*N];
  logic [MAX_W-1:0]  c_full;
  logic [PROD_W-1:0] term;
  logic [PROD_W-1:0] u_sum;
  logic [DATA_W-1:0] res_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (mul_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (mul_en) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // S1: operand capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_a  <= '0;
      s1_b  <= '0;
      s1_op <= MUL_LO;
    end else if (mul_en) begin
      s1_a  <= mul_src1;
      s1_b  <= mul_src2;
      s1_op <= mul_op_e'(mul_op);
    end
  end

  // S2: slice products plus the signed correction term
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      nios2_fp_mult_slice #(
        .PART_W (PART_W)
      ) u_slice (
        .clk (clk),
        .rst (reset),
        .en  (mul_en),
        .a   (s1_a[i*PART_W +: PART_W]),
        .b   (s1_b[j*PART_W +: PART_W]),
        .p   (pp[i*N+j])
      );
    end
  end

  assign c_full = hi_correction(MAX_W'(s1_a), MAX_W'(s1_b), s1_op, DATA_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_op <= MUL_LO;
      s2_c  <= '0;
    end else if (mul_en) begin
      s2_op <= s1_op;
      s2_c  <= c_full[DATA_W-1:0];
    end
  end

  // S3: recombine the slice products and select the requested half
  always_comb begin
    term  = '0;
    u_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        term             = '0;
        term[PP_W-1:0]   = pp[i*N+j];
        u_sum            = u_sum + (term << (PART_W * (i + j)));
      end
    end
    if (s2_op == MUL_LO) begin
      res_next = u_sum[DATA_W-1:0];
    end else begin
      res_next = u_sum[PROD_W-1:DATA_W] - s2_c;
    end
  end

  // Result only moves when a live op lands in S3, so it holds after out_valid drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_result <= '0;
    end else if (mul_en && s2_valid && !mul_flush) begin
      mul_result <= res_next;
    end
  end

  assign out_valid = s3_valid;
  assign busy      = s1_valid | s2_valid | s3_valid;

endmodule

// File: tb/tb_nios2_fp_cpu_mult_pipe.sv
// Scoreboard bench for nios2_fp_cpu_mult_pipe (32/16): directed vectors,
// stall and flush sequences, then a randomised mixed-control run.
module tb_nios2_fp_cpu_mult_pipe;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_XUU = 2'b01;
  localparam logic [1:0] OP_XSU = 2'b10;
  localparam logic [1:0] OP_XSS = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        mul_en;
  logic        mul_flush;
  logic        in_valid;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic [1:0]  mul_op;
  logic        out_valid;
  logic [31:0] mul_result;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb [$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned ecount   = 0;
  logic        mon_on   = 1'b0;
  logic        m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;
  logic        have_last = 1'b0;
  logic [31:0] last_exp = '0;
  logic        rst_q, en_q, fl_q, iv_q, new_out;
  exp_t        e;

  nios2_fp_cpu_mult_pipe #(
    .DATA_W (32),
    .PART_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mul_en     (mul_en),
    .mul_flush  (mul_flush),
    .in_valid   (in_valid),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_op     (mul_op),
    .out_valid  (out_valid),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] ax, bx, p;
    ax = {32'h0, a};
    bx = {32'h0, b};
    if (op[1])         ax = {{32{a[31]}}, a};
    if (op == OP_XSS)  bx = {{32{b[31]}}, b};
    p = ax * bx;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: independent valid-pipeline model plus scoreboard pop on each new result
  always @(posedge clk) begin
    rst_q = reset;
    en_q  = mul_en;
    fl_q  = mul_flush;
    iv_q  = in_valid;
    if (rst_q) begin
      m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
    end else begin
      if (en_q) ecount++;
      if (fl_q) begin
        m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
      end else if (en_q) begin
        m3 = m2; m2 = m1; m1 = iv_q;
      end
    end
    new_out = !rst_q && !fl_q && en_q && m3;
    #1;
    if (mon_on) begin
      chk("out_valid", {63'h0, out_valid}, {63'h0, m3});
      chk("busy", {63'h0, busy}, {63'h0, m1 | m2 | m3});
      if (new_out) begin
        chk("sb_nonempty", {63'h0, sb.size() != 0}, 64'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result", {32'h0, mul_result}, {32'h0, e.res});
          chk("latency", 64'(ecount), 64'(e.cyc));
          last_exp  = e.res;
          have_last = 1'b1;
        end
      end else if (have_last) begin
        chk("result_hold", {32'h0, mul_result}, {32'h0, last_exp});
      end
    end
  end

  task automatic drive(input logic en, input logic fl, input logic iv,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    mul_en = en; mul_flush = fl; in_valid = iv;
    mul_src1 = a; mul_src2 = b; mul_op = op;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] exp);
    drive(1'b1, 1'b0, 1'b1, a, b, op);
    sb.push_back('{exp, ecount + 3});
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, '0, '0, OP_MUL);
  endtask

  task automatic drain();
    int unsigned k;
    k = 0;
    while ((sb.size() != 0 || m1 || m2 || m3) && k < 40) begin
      idle(1);
      k++;
    end
    chk("drain_empty", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        en, fl, iv;

    reset = 1'b1; mul_en = 1'b0; mul_flush = 1'b0; in_valid = 1'b0;
    mul_src1 = '0; mul_src2 = '0; mul_op = OP_MUL;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_result", {32'h0, mul_result}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Pipeline fill
    issue(32'h0001_0000, 32'h0001_0000, OP_MUL, 32'h0000_0000);
    drain();
    issue(32'h0001_0000, 32'h0001_0000, OP_XUU, 32'h0000_0001);
    drain();

    // Signedness sweep, back-to-back
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, 32'h0000_0001);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_XUU, 32'hFFFF_FFFE);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_XSU, 32'hFFFF_FFFF);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_XSS, 32'h0000_0000);
    drain();

    // Corners
    issue(32'h8000_0000, 32'h8000_0000, OP_XSS, 32'h4000_0000);
    issue(32'h8000_0000, 32'h0000_0002, OP_XSU, 32'hFFFF_FFFF);
    drain();

    // Stall for 5 cycles with garbage in_valid while results are in flight
    issue(32'h0000_0003, 32'h0000_0005, OP_MUL, 32'h0000_000F);
    issue(32'h8000_0000, 32'h0000_0004, OP_XUU, 32'h0000_0002);
    issue(32'hFFFF_FFFE, 32'h0000_0003, OP_XSS, 32'hFFFF_FFFF);
    repeat (5) drive(1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, OP_XUU);
    idle(1);
    drain();

    // Flush with simultaneous in_valid: all three ops dropped
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0011, 32'h0000_0022, OP_MUL);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0033, 32'h0000_0044, OP_MUL);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0055, 32'h0000_0066, OP_MUL);
    idle(1);
    chk("flush_busy", {63'h0, busy}, 64'h0);
    issue(32'h0000_0007, 32'h0000_0006, OP_MUL, 32'h0000_002A);
    drain();

    // Flush while stalled
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0009, 32'h0000_0009, OP_MUL);
    drive(1'b0, 1'b1, 1'b0, '0, '0, OP_MUL);
    idle(1);
    chk("flush_stall_busy", {63'h0, busy}, 64'h0);
    issue(32'hFFFF_FFFF, 32'h0000_0002, OP_XSU, 32'hFFFF_FFFF);
    drain();

    // Randomised operands, ops, enable and flush
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      iv = ($urandom_range(0, 4) != 0);
      a  = pick();
      b  = pick();
      op = 2'($urandom_range(0, 3));
      drive(en, fl, iv, a, b, op);
      if (fl) sb.delete();
      else if (en && iv) sb.push_back('{ref_mul(a, b, op), ecount + 3});
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
